// File: rtl/halflife_pkg.sv
// Shared definitions for the halflife_timer block: step modes and their width.
package halflife_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        HOLD  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        DECAY = 2'd3
    } mode_e;

endpackage

// File: rtl/halflife_prescaler.sv
// Step-interval prescaler: counts 0..period and emits a one-cycle step at period.
module halflife_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] period,
    output logic               step
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;

    always_comb begin
        step  = 1'b0;
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == period) begin
                step  = 1'b1;
                cnt_d = '0;
            end else if (cnt_q > period) begin
                // period shrank below the running count: restart without stepping
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/halflife_timer.sv
// Programmable up/down/half-life counter stepped by a prescaler, with tick and expiry pulses.
module halflife_timer
    import halflife_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESC_W  = 8,
    parameter int SATURATE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [MODE_W-1:0]  mode,
    input  logic [PRESC_W-1:0] period,
    output logic [WIDTH-1:0]   out,
    output logic               tick,
    output logic               zero,
    output logic               full,
    output logic               expired
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic             step;
    logic [WIDTH-1:0] out_q, out_d, stepped;
    logic             tick_q, tick_d;
    logic             exp_q, exp_d;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

    halflife_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (load),
        .period (period),
        .step   (step)
    );

    always_comb begin
        stepped = out_q;
        unique case (mode_s)
            UP:      stepped = (out_q == ALL_ONES) ? ((SATURATE != 0) ? out_q : '0)
                                                   : out_q + WIDTH'(1);
            DOWN:    stepped = (out_q == '0) ? ((SATURATE != 0) ? out_q : ALL_ONES)
                                             : out_q - WIDTH'(1);
            DECAY:   stepped = out_q >> 1;
            default: stepped = out_q;
        endcase
    end

    // load dominates; the prescaler is cleared by load so step is already 0 then
    always_comb begin
        out_d  = out_q;
        tick_d = 1'b0;
        exp_d  = 1'b0;
        if (load) begin
            out_d = load_val;
        end else if (step) begin
            out_d  = stepped;
            tick_d = 1'b1;
            exp_d  = (out_q != '0) && (stepped == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            tick_q <= 1'b0;
            exp_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            tick_q <= tick_d;
            exp_q  <= exp_d;
        end
    end

    assign out     = out_q;
    assign tick    = tick_q;
    assign expired = exp_q;
    assign zero    = (out_q == '0);
    assign full    = (out_q == ALL_ONES);

endmodule

// File: tb/tb_halflife_timer.sv
// Self-checking bench: saturating and wrapping instances against an arithmetic reference model.
module tb_halflife_timer;
    import halflife_pkg::*;

    localparam int W   = 8;
    localparam int PW  = 8;
    localparam int MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [1:0]    mode = 2'd0;
    logic [PW-1:0] period = '0;

    logic [W-1:0] out_s, out_w;
    logic tick_s, tick_w, zero_s, zero_w, full_s, full_w, exp_s, exp_w;

    always #5 clk = ~clk;

    halflife_timer #(.WIDTH(W), .PRESC_W(PW), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .mode(mode), .period(period), .out(out_s), .tick(tick_s),
        .zero(zero_s), .full(full_s), .expired(exp_s)
    );

    halflife_timer #(.WIDTH(W), .PRESC_W(PW), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .mode(mode), .period(period), .out(out_w), .tick(tick_w),
        .zero(zero_w), .full(full_w), .expired(exp_w)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference state: index 0 = saturating, 1 = wrapping
    int m_cnt;
    int m_out [2];
    bit m_tick;
    bit m_exp [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp_v, $time);
        end
    endtask

    function automatic int next_val(input int v, input int md, input bit sat);
        case (md)
            1:       return (v == MAXV) ? (sat ? MAXV : 0) : v + 1;
            2:       return (v == 0) ? (sat ? 0 : MAXV) : v - 1;
            3:       return v / 2;
            default: return v;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_tick = 0;
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0;
            m_exp[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit st;
        st     = 0;
        m_tick = 0;
        m_exp[0] = 0;
        m_exp[1] = 0;
        if (load) begin
            m_cnt = 0;
            m_out[0] = int'(load_val);
            m_out[1] = int'(load_val);
        end else if (en) begin
            if (m_cnt == int'(period)) begin
                st = 1;
                m_cnt = 0;
            end else if (m_cnt > int'(period)) m_cnt = 0;
            else m_cnt++;
            if (st) begin
                m_tick = 1;
                for (int k = 0; k < 2; k++) begin
                    int nv;
                    nv = next_val(m_out[k], int'(mode), (k == 0));
                    m_exp[k] = (m_out[k] != 0) && (nv == 0);
                    m_out[k] = nv;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_s"},  32'(out_s),  32'(m_out[0]));
        chk({tag, ".out_w"},  32'(out_w),  32'(m_out[1]));
        chk({tag, ".tick_s"}, 32'(tick_s), 32'(m_tick));
        chk({tag, ".tick_w"}, 32'(tick_w), 32'(m_tick));
        chk({tag, ".exp_s"},  32'(exp_s),  32'(m_exp[0]));
        chk({tag, ".exp_w"},  32'(exp_w),  32'(m_exp[1]));
        chk({tag, ".zero_s"}, 32'(zero_s), 32'(m_out[0] == 0));
        chk({tag, ".full_w"}, 32'(full_w), 32'(m_out[1] == MAXV));
    endtask

    // one clock: model follows the edge, outputs sampled 1 time unit later
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // called at posedge+1: pulse reset low between edges
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk({tag, ".out_s"},  32'(out_s),  32'd0);
        chk({tag, ".tick_s"}, 32'(tick_s), 32'd0);
        chk({tag, ".exp_s"},  32'(exp_s),  32'd0);
        chk({tag, ".zero_s"}, 32'(zero_s), 32'd1);
        chk({tag, ".full_s"}, 32'(full_s), 32'd0);
        #1 rst = 1'b1;
    endtask

    task automatic set_in(input bit ld, input int lv, input int md, input int pr, input bit e);
        load = ld; load_val = W'(lv); mode = 2'(md); period = PW'(pr); en = e;
    endtask

    initial begin
        int ticks, exps;
        int dseq [8] = '{100, 50, 25, 12, 6, 3, 1, 0};
        model_reset();
        #12;
        chk("rst.out_s", 32'(out_s), 32'd0);
        chk("rst.tick_w", 32'(tick_w), 32'd0);
        chk("rst.zero_s", 32'(zero_s), 32'd1);
        chk("rst.full_s", 32'(full_s), 32'd0);
        #2 rst = 1'b1;

        // half-life decay from 200, period 3
        set_in(1, 200, 3, 3, 1);
        cyc("decay.ld");
        load = 0;
        exps = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                cyc("decay");
                exps += int'(exp_s);
            end
            chk("decay.seq", 32'(out_s), 32'(dseq[i]));
            chk("decay.tick", 32'(tick_s), 32'd1);
        end
        chk("decay.exp_once", 32'(exps), 32'd1);
        ticks = 0;
        for (int j = 0; j < 8; j++) begin
            cyc("decay0");
            ticks += int'(tick_s);
        end
        chk("decay0.ticks", 32'(ticks), 32'd2);

        // up to the top: saturate vs wrap
        set_in(1, 254, 1, 0, 1);
        cyc("up.ld");
        load = 0;
        cyc("up1");
        chk("up1.out_s", 32'(out_s), 32'd255);
        cyc("up2");
        chk("up2.out_s", 32'(out_s), 32'd255);
        chk("up2.full_s", 32'(full_s), 32'd1);
        chk("up2.out_w", 32'(out_w), 32'd0);

        // down through zero
        set_in(1, 1, 2, 0, 1);
        cyc("dn.ld");
        load = 0;
        cyc("dn1");
        chk("dn1.out_w", 32'(out_w), 32'd0);
        chk("dn1.exp_w", 32'(exp_w), 32'd1);
        cyc("dn2");
        chk("dn2.out_w", 32'(out_w), 32'd255);
        chk("dn2.exp_s", 32'(exp_s), 32'd0);
        cyc("dn3");
        chk("dn3.out_w", 32'(out_w), 32'd254);
        chk("dn3.out_s", 32'(out_s), 32'd0);

        // load on the step cycle
        set_in(1, 10, 1, 2, 1);
        cyc("lds.ld");
        load = 0;
        cyc("lds"); cyc("lds");
        set_in(1, 77, 1, 2, 1);
        cyc("lds.hit");
        chk("lds.hit.out", 32'(out_s), 32'd77);
        chk("lds.hit.tick", 32'(tick_s), 32'd0);
        load = 0;
        cyc("lds"); cyc("lds");
        chk("lds.notyet", 32'(tick_s), 32'd0);
        cyc("lds");
        chk("lds.out78", 32'(out_s), 32'd78);

        // freeze mid-interval
        set_in(1, 0, 1, 7, 1);
        cyc("frz.ld");
        load = 0;
        repeat (3) cyc("frz.run");
        en = 0;
        repeat (5) cyc("frz.off");
        en = 1;
        repeat (4) cyc("frz.resume");
        chk("frz.early", 32'(out_s), 32'd0);
        cyc("frz.step");
        chk("frz.step.out", 32'(out_s), 32'd1);
        chk("frz.step.tick", 32'(tick_s), 32'd1);

        // async reset mid-decay
        set_in(1, 200, 3, 1, 1);
        cyc("ard.ld");
        load = 0;
        repeat (3) cyc("ard");
        async_reset("ard.rst");
        repeat (4) cyc("ard.post");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(7) != 0);
            load = ($urandom_range(15) == 0);
            load_val = W'($urandom);
            if ($urandom_range(9) == 0) mode = 2'($urandom);
            if ($urandom_range(19) == 0) period = PW'($urandom_range(6));
            if (load && $urandom_range(1) == 0) load_val = W'($urandom_range(2));
            cyc("rnd");
            if ($urandom_range(199) == 0) async_reset("rnd.rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/halflife_timer.md
HALFLIFE_TIMER -- requirements
Module: halflife_timer

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits.
REQ-002 Parameter PRESC_W, default 8: prescaler/period width in bits.
REQ-003 Parameter SATURATE, default 1: 1 = clamp at bounds, 0 = wrap-around.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port en, input, 1: enables the prescaler and counting; 0 = freeze all state except load.
REQ-007 Port load, input, 1: synchronous load of load_val.
REQ-008 Port load_val, input, WIDTH: value for load.
REQ-009 Port mode, input, 2: HOLD=0, UP=1, DOWN=2, DECAY=3.
REQ-010 Port period, input, PRESC_W: step interval of period+1 clk cycles.
REQ-011 Port out, output, WIDTH: current count, registered.
REQ-012 Port tick, output, 1: registered one-cycle pulse for each step interval elapsed.
REQ-013 Port zero, output, 1: out == 0 (combinational from out).
REQ-014 Port full, output, 1: out == all-ones (combinational from out).
REQ-015 Port expired, output, 1: registered one-cycle pulse when out becomes 0 through a step.

Function
REQ-016 The prescaler shall count 0..period while en=1 and shall assert an internal step on the cycle it equals period, then return to 0; period=0 shall give a step every enabled cycle.
REQ-017 The block shall register tick one cycle after the internal step (tick latency 1).
REQ-018 Priority shall be load > step > hold; out shall follow this table.
- load=1: out<=load_val, prescaler<=0, no tick or expired that cycle, regardless of en.
- step in UP: out<=out+1; at all-ones, hold (SATURATE=1) or wrap to 0 (SATURATE=0).
- step in DOWN: out<=out-1; at 0, hold (SATURATE=1) or wrap to all-ones (SATURATE=0).
- step in DECAY: out<=out>>1 (one half-life per step); 1 goes to 0; 0 stays 0.
- step in HOLD: out unchanged; tick still pulses.
REQ-019 expired shall pulse only on a transition from nonzero to 0 through a step, never on load or on 0 -> 0 steps.
REQ-020 With en=0, the prescaler and out shall hold, and tick and expired shall be 0.
REQ-021 A mode change shall not reset the prescaler; the new mode shall apply at the next step.
REQ-022 A change to period mid-interval shall take effect immediately: if the prescaler exceeds the new period, it shall wrap to 0 on the next enabled cycle with no step.
REQ-023 All arithmetic shall be WIDTH-bit unsigned; no carry shall leak into out.

Reset
REQ-024 When rst=0, out, the prescaler, tick and expired shall clear to 0 asynchronously; zero shall then read 1 and full shall read 0.
REQ-025 Reset deassertion shall be synchronised by the integrating parent; the first enabled cycle after release shall count as prescaler value 0.
REQ-026 Reset asserted mid-interval shall discard any pending step and tick.

Structure
REQ-027 Package halflife_pkg shall hold the mode enum (HOLD/UP/DOWN/DECAY) and the mode width constant.
REQ-028 The prescaler shall be a sub-module halflife_prescaler (clk, rst, en, clr, period -> step).
REQ-029 The block shall contain no latches and no combinational path from inputs to out, tick or expired.

Verification
REQ-030 Bench scenario: WIDTH=8, load 200, DECAY, period=3, en=1 -> out steps 200,100,50,25,12,6,3,1,0 every 4 cycles; expired pulses once; tick keeps pulsing at 0.
REQ-031 Bench scenario: SATURATE=1, load 254, UP, period=0 -> out 255, then holds 255; full=1.
REQ-032 Bench scenario: SATURATE=0, load 1, DOWN, period=0 -> out 0 (expired pulse), then 255, then 254.
REQ-033 Bench scenario: load asserted on the same cycle as a step -> out=load_val, prescaler restarts, no tick or expired.
REQ-034 Bench scenario: en dropped mid-interval for 5 cycles -> out and prescaler frozen; resume completes the remaining count exactly.
REQ-035 Bench scenario: rst pulsed low asynchronously between edges mid-DECAY -> out=0 and tick=0 immediately; no expired pulse.
